sync_fifo_flags: RTL and testbench



---
 rtl/sync_fifo_flags.sv | 91 +++++++++
 tb/tb_sync_fifo_flags.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with arbitrary depth, selectable show-ahead or registered read,
// occupancy count, almost-full/almost-empty thresholds, sticky error flags and flush.
module sync_fifo_flags #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter bit FWFT       = 1'b1,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         wr_en,
   input  logic                         rd_en,
   input  logic [DATA_WIDTH-1:0]        data_in,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic                  wr_acc, rd_acc;

   // flush wins over both requests, so it also masks acceptance
   assign wr_acc = wr_en & ~full  & ~flush;
   assign rd_acc = rd_en & ~empty & ~flush;

   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_LEVEL));
   assign almost_empty = (count <= CW'(AE_LEVEL));

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (wr_en & full)  overflow  <= 1'b1;
         if (rd_en & empty) underflow <= 1'b1;
      end
   end

   // storage is intentionally not reset
   always_ff @(posedge clock) begin
      if (wr_acc) mem[wr_ptr] <= data_in;
   end

   generate
      if (FWFT) begin : g_fwft
         assign data_out = empty ? '0 : mem[rd_ptr];
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clock or posedge reset) begin
            if (reset)       dout_q <= '0;
            else if (flush)  dout_q <= '0;
            else if (rd_acc) dout_q <= mem[rd_ptr];
         end
         assign data_out = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: three FIFO configurations share stimulus; a queue-based model
// pushes expected outputs per cycle and a negedge monitor pops and compares them.
module tb_sync_fifo_flags;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       flush = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] data_in = '0;

   logic [2:0][7:0] dout_v;
   logic [2:0]      full_v, empty_v, af_v, ae_v, ovf_v, unf_v;
   logic [2:0]      cnt_a, cnt_b;
   logic [4:0]      cnt_c;
   logic [4:0]      cnt_v [3];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // per-instance configuration: A=5/FWFT, B=6/FWFT (AF at DEPTH, AE=0), C=16/registered
   int dep  [3] = '{5, 6, 16};
   bit fwft [3] = '{1'b1, 1'b1, 1'b0};
   int afl  [3] = '{4, 6, 14};
   int ael  [3] = '{1, 0, 2};

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1'b1), .AF_LEVEL(4), .AE_LEVEL(1)) u_a (
      .clock(clock), .reset(reset), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
      .data_in(data_in), .data_out(dout_v[0]), .full(full_v[0]), .empty(empty_v[0]),
      .almost_full(af_v[0]), .almost_empty(ae_v[0]), .count(cnt_a),
      .overflow(ovf_v[0]), .underflow(unf_v[0]));

   sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(1'b1), .AF_LEVEL(6), .AE_LEVEL(0)) u_b (
      .clock(clock), .reset(reset), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
      .data_in(data_in), .data_out(dout_v[1]), .full(full_v[1]), .empty(empty_v[1]),
      .almost_full(af_v[1]), .almost_empty(ae_v[1]), .count(cnt_b),
      .overflow(ovf_v[1]), .underflow(unf_v[1]));

   sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b0), .AF_LEVEL(14), .AE_LEVEL(2)) u_c (
      .clock(clock), .reset(reset), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
      .data_in(data_in), .data_out(dout_v[2]), .full(full_v[2]), .empty(empty_v[2]),
      .almost_full(af_v[2]), .almost_empty(ae_v[2]), .count(cnt_c),
      .overflow(ovf_v[2]), .underflow(unf_v[2]));

   assign cnt_v[0] = {2'b00, cnt_a};
   assign cnt_v[1] = {2'b00, cnt_b};
   assign cnt_v[2] = cnt_c;

   // reference model: FIFO contents as a queue, sticky flags, registered-read word
   logic [7:0] mq [3][$];
   bit         ovf_m  [3];
   bit         unf_m  [3];
   logic [7:0] dreg_m [3];

   typedef struct {
      int         cyc;
      int         inst;
      logic [7:0] dout;
      int         cnt;
      bit         full, empty, af, ae, ovf, unf;
   } exp_t;

   exp_t exp_q[$];

   function automatic exp_t mk_exp(int i, int c);
      exp_t e;
      int   n = mq[i].size();
      e.cyc   = c;
      e.inst  = i;
      e.cnt   = n;
      e.full  = (n == dep[i]);
      e.empty = (n == 0);
      e.af    = (n >= afl[i]);
      e.ae    = (n <= ael[i]);
      e.ovf   = ovf_m[i];
      e.unf   = unf_m[i];
      if (fwft[i]) e.dout = (n > 0) ? mq[i][0] : 8'h00;
      else         e.dout = dreg_m[i];
      return e;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         ovf_m[i]  = 1'b0;
         unf_m[i]  = 1'b0;
         dreg_m[i] = 8'h00;
      end
   endfunction

   function automatic void model_step(int i, bit w, bit r, bit f, logic [7:0] d);
      int n = mq[i].size();
      if (f) begin
         mq[i].delete();
         ovf_m[i]  = 1'b0;
         unf_m[i]  = 1'b0;
         dreg_m[i] = 8'h00;
         return;
      end
      if (w && n == dep[i]) ovf_m[i] = 1'b1;
      if (r && n == 0)      unf_m[i] = 1'b1;
      if (r && n > 0)       dreg_m[i] = mq[i].pop_front();
      if (w && n < dep[i])  mq[i].push_back(d);
   endfunction

   task automatic cmp(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic check(exp_t e, string tag);
      int i = e.inst;
      cmp($sformatf("%s[%0d].data_out", tag, i), int'(dout_v[i]), int'(e.dout));
      cmp($sformatf("%s[%0d].count", tag, i), int'(cnt_v[i]), e.cnt);
      cmp($sformatf("%s[%0d].full", tag, i), int'(full_v[i]), int'(e.full));
      cmp($sformatf("%s[%0d].empty", tag, i), int'(empty_v[i]), int'(e.empty));
      cmp($sformatf("%s[%0d].almost_full", tag, i), int'(af_v[i]), int'(e.af));
      cmp($sformatf("%s[%0d].almost_empty", tag, i), int'(ae_v[i]), int'(e.ae));
      cmp($sformatf("%s[%0d].overflow", tag, i), int'(ovf_v[i]), int'(e.ovf));
      cmp($sformatf("%s[%0d].underflow", tag, i), int'(unf_v[i]), int'(e.unf));
   endtask

   task automatic check_now(string tag);
      for (int i = 0; i < 3; i++) check(mk_exp(i, 0), tag);
   endtask

   // monitor: compare every expectation that targets the cycle just completed
   always @(negedge clock) begin : monitor
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         if (e.cyc < cyc) begin
            bad++;
            $display("FAIL stale_expectation inst=%0d actual_cyc=%0d expected_cyc=%0d", e.inst, cyc, e.cyc);
         end else begin
            check(e, "sb");
         end
      end
   end

   task automatic step(bit w, bit r, bit f, logic [7:0] d);
      wr_en   = w;
      rd_en   = r;
      flush   = f;
      data_in = d;
      for (int i = 0; i < 3; i++) begin
         model_step(i, w, r, f, d);
         exp_q.push_back(mk_exp(i, cyc + 1));
      end
      @(posedge clock);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      flush = 1'b0;
   endtask

   task automatic async_reset(string tag);
      @(negedge clock);
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      check_now(tag);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_now("reset");
      reset = 1'b0;

      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);

      // fill past full: A full after 5, 6th write overflows A; B fills to 6
      for (int k = 0; k < 6; k++) step(1, 0, 0, 8'hA0 + 8'(k));
      // drain; A underflows on its 6th read
      for (int k = 0; k < 6; k++) step(0, 1, 0, 8'h00);

      // registered-read hold behaviour
      step(0, 0, 1, 8'h00);
      step(1, 0, 0, 8'h11);
      step(1, 0, 0, 8'h22);
      step(0, 1, 0, 8'h00);
      step(0, 1, 0, 8'h00);
      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);
      step(0, 1, 0, 8'h00);

      // simultaneous on empty
      step(0, 0, 1, 8'h00);
      step(1, 1, 0, 8'h5A);
      step(0, 0, 1, 8'h00);

      // simultaneous at count 8
      for (int k = 0; k < 8; k++) step(1, 0, 0, 8'h30 + 8'(k));
      for (int k = 0; k < 4; k++) step(1, 1, 0, 8'h40 + 8'(k));
      step(0, 0, 1, 8'h00);

      // threshold walk 0..16 and one write past full, then simultaneous on full
      for (int k = 0; k < 17; k++) step(1, 0, 0, 8'h60 + 8'(k));
      step(1, 1, 0, 8'hEE);
      for (int k = 0; k < 3; k++) step(0, 1, 0, 8'h00);

      // random interleaving with occasional flush
      step(0, 0, 1, 8'h00);
      for (int k = 0; k < 300; k++)
         step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
              $urandom_range(0, 59) == 0, 8'($urandom));

      // flush with wr_en at count 4
      step(0, 0, 1, 8'h00);
      for (int k = 0; k < 4; k++) step(1, 0, 0, 8'hC0 + 8'(k));
      step(1, 0, 1, 8'hFF);
      step(0, 0, 0, 8'h00);

      // asynchronous reset with count 5, then a read underflows
      for (int k = 0; k < 5; k++) step(1, 0, 0, 8'hD0 + 8'(k));
      async_reset("midrst");
      step(0, 1, 0, 8'h00);
      step(0, 0, 0, 8'h00);

      repeat (2) @(posedge clock);
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expectations actual=%0d expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
